fft_stage_scheduler: RTL and testbench
======================================

// Module: fft_stage_scheduler
// PURPOSE
//  Sequences an in-place radix-2 DIT FFT over one shared butterfly unit and a ping-pong sample memory.
//  Walks all LOG2N stages; for each stage it issues N/2 butterfly requests (pair addresses + twiddle address).
//  It holds the next stage until every outstanding butterfly result has been written back.
//  Sits between the frame buffer (start) and the butterfly/memory datapath in the MFCC front end.
// PARAMETERS
//  N         256  FFT length, power of two, >= 4
//  LOG2N     8    log2(N); must match N
//  MAX_OUT   4    max butterfly requests in flight (1..15)
// PORTS
//  clk            in   1      clock, all logic rising-edge
//  reset          in   1      asynchronous, active-low reset
//  start          in   1      begin a transform; sampled only in IDLE
//  busy           out  1      high from the cycle after start until DONE, inclusive
//  done           out  1      one-cycle pulse, transform complete
//  stage          out  LOG2N  current stage index (0..LOG2N-1)
//  rd_bank        out  1      ping-pong bank to read; butterfly writes go to ~rd_bank
//  bf_req_valid   out  1      butterfly request valid
//  bf_req_ready   in   1      butterfly accepts request
//  bf_addr_a      out  LOG2N  upper-leg sample address
//  bf_addr_b      out  LOG2N  lower-leg sample address
//  bf_tw_addr     out  LOG2N-1  twiddle ROM address
//  bf_rsp_valid   in   1      one butterfly result written back
//  err_unexp_rsp  out  1      sticky: bf_rsp_valid seen with zero outstanding
//  cycle_count    out  32     cycles from start accept to done (stats build only)
//  stall_count    out  32     cycles with bf_req_valid & !bf_req_ready (stats build only)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, bf_req_valid, err_unexp_rsp, rd_bank, stage, addresses, counters = 0.
//  States: IDLE -> ISSUE (start) -> DRAIN (last pair of stage handshaken) -> NEXT (outstanding==0)
//          NEXT -> ISSUE (stage<LOG2N-1: stage++, rd_bank toggles, pair k=0) | DONE (last stage)
//          DONE -> IDLE after one cycle; done=1 only in DONE.
//  Pair k (0..N/2-1) in stage s: half=1<<s, pos=k&(half-1), grp=k>>s;
//    addr_a=(grp<<(s+1))|pos, addr_b=addr_a+half, tw_addr=pos<<(LOG2N-1-s). All registered outputs.
//  bf_req_valid=1 in ISSUE while outstanding<MAX_OUT; addresses stable while valid & !ready.
//  Handshake (valid&ready): k++, outstanding++. bf_rsp_valid: outstanding--. Both same cycle: unchanged.
//  Response with outstanding==0: counter stays 0, err_unexp_rsp set (cleared only by reset).
//  start outside IDLE ignored. Reset mid-transform: immediate return to IDLE, no done pulse.
//  Zero-latency path: start in cycle 0 -> first request visible cycle 1.
// CONFIGURATION
//  FFT_SCHED_STATS_EN defined: cycle_count/stall_count count, cleared on start accept, frozen after done.
//  Undefined: counter logic omitted; both ports tied to 0.
// STRUCTURE
//  fft_pkg: state encoding localparams, MAX_OUT width constant, clog2 helper.
//  Sub-module fft_pair_addr_gen: combinational (s,k)->(addr_a,addr_b,tw_addr), registered in parent.
// TESTING
//  N=8, ready=1, rsp 1 cycle after accept: stage1 requests (0,2,tw0)(1,3,tw2)(4,6,tw0)(5,7,tw2); done once.
//  Stage0 N=8: pairs (0,1),(2,3),(4,5),(6,7) all tw0; stage2: (0,4,tw0)(1,5,tw1)(2,6,tw2)(3,7,tw3).
//  MAX_OUT=2, responses withheld: exactly 2 accepts then valid drops; state stays DRAIN/ISSUE until rsp.
//  ready held low 5 cycles mid-stage: addresses unchanged; stats build stall_count=5.
//  rsp pulse in IDLE -> err_unexp_rsp=1, stays 1; reset low mid-stage 2 -> IDLE, busy=0, no done.
//  start asserted while busy -> ignored; rd_bank sequence 0,1,0 across 3 stages (N=8).

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : state encoding and sizing helpers for the FFT stage scheduler
// Rev 1.0 : initial release
// ============================================================================
package fft_pkg;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

    localparam int STATE_W       = 3;
    localparam int MAX_OUT_LIMIT = 15;
    localparam int OUT_CNT_W     = clog2(MAX_OUT_LIMIT + 1);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_pair_addr_gen.sv
`default_nettype none
// ============================================================================
// fft_pair_addr_gen : maps (stage, pair index) to butterfly leg and twiddle addresses
// Rev 1.0 : initial release
// ============================================================================
module fft_pair_addr_gen #(
    parameter int LOG2N = 8
) (
    input  logic [LOG2N-1:0] stage,
    input  logic [LOG2N-2:0] pair,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);
    logic [LOG2N-1:0] one;
    logic [LOG2N-1:0] top_stage;
    logic [LOG2N-1:0] pair_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;

    assign one       = {{(LOG2N-1){1'b0}}, 1'b1};
    assign top_stage = LOG2N'(LOG2N - 1);
    assign pair_ext  = {1'b0, pair};

    assign half   = one << stage;
    assign pos    = pair_ext & (half - one);
    assign grp    = pair_ext >> stage;
    // Group base skips the lower half of each butterfly span.
    assign addr_a = (grp << (stage + one)) | pos;
    assign addr_b = addr_a | half;
    // pos < N/2 always, so it fits the narrower twiddle width before shifting.
    assign tw_addr = pos[LOG2N-2:0] << (top_stage - stage);

endmodule
`default_nettype wire

// File: rtl/fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
// fft_stage_scheduler : issues radix-2 DIT butterfly requests stage by stage
// Optional statistics counters enabled by defining FFT_SCHED_STATS_EN.
// Rev 1.0 : initial release
// ============================================================================
module fft_stage_scheduler #(
    parameter int N       = 256,
    parameter int LOG2N   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_bank,
    output logic             bf_req_valid,
    input  logic             bf_req_ready,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] bf_tw_addr,
    input  logic             bf_rsp_valid,
    output logic             err_unexp_rsp,
    output logic [31:0]      cycle_count,
    output logic [31:0]      stall_count
);
    import fft_pkg::*;

    localparam int PAIR_W = LOG2N - 1;

    sched_state_t           state_q, state_d;
    logic [LOG2N-1:0]       stage_q, stage_d;
    logic [PAIR_W-1:0]      pair_q, pair_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [OUT_CNT_W-1:0]   outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic [LOG2N-1:0]       addr_a_q, addr_b_q, addr_a_d, addr_b_d;
    logic [PAIR_W-1:0]      tw_q, tw_d;

    logic req_valid;
    logic req_fire;
    logic last_pair;
    logic last_stage;
    logic start_accept;

    assign req_valid    = (state_q == ST_ISSUE) && (outstanding_q < OUT_CNT_W'(MAX_OUT));
    assign req_fire     = req_valid && bf_req_ready;
    assign last_pair    = (pair_q == PAIR_W'(N/2 - 1));
    assign last_stage   = (stage_q == LOG2N'(LOG2N - 1));
    assign start_accept = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        pair_d    = pair_q;
        rd_bank_d = rd_bank_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d   = ST_ISSUE;
                    stage_d   = '0;
                    pair_d    = '0;
                    rd_bank_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (req_fire) begin
                    pair_d = pair_q + 1'b1;
                    if (last_pair) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_stage) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_ISSUE;
                    stage_d   = stage_q + 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    pair_d    = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A simultaneous accept and write-back cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (bf_rsp_valid && (outstanding_q == '0)) begin
            err_d = 1'b1;
        end
        case ({req_fire, bf_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Addresses are computed from the next pair so they register in step with it.
    fft_pair_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage   (stage_d),
        .pair    (pair_d),
        .addr_a  (addr_a_d),
        .addr_b  (addr_b_d),
        .tw_addr (tw_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            pair_q        <= '0;
            rd_bank_q     <= 1'b0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            tw_q          <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            pair_q        <= pair_d;
            rd_bank_q     <= rd_bank_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            tw_q          <= tw_d;
        end
    end

`ifdef FFT_SCHED_STATS_EN
    logic [31:0] cycle_q;
    logic [31:0] stall_q;

    // Counters run only outside IDLE, so they hold their value after done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else if (start_accept) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (req_valid && !bf_req_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign stall_count = stall_q;
`else
    assign cycle_count = '0;
    assign stall_count = '0;
`endif

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign stage         = stage_q;
    assign rd_bank       = rd_bank_q;
    assign bf_req_valid  = req_valid;
    assign bf_addr_a     = addr_a_q;
    assign bf_addr_b     = addr_b_q;
    assign bf_tw_addr    = tw_q;
    assign err_unexp_rsp = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fft_stage_scheduler : randomized bench for N=8, MAX_OUT=2 against a pair-list model
// Rev 1.0 : initial release
// ============================================================================
module tb_fft_stage_scheduler;
    localparam int N       = 8;
    localparam int LOG2N   = 3;
    localparam int MAX_OUT = 2;

    logic             clk           = 1'b0;
    logic             reset         = 1'b0;
    logic             start         = 1'b0;
    logic             bf_req_ready  = 1'b0;
    logic             bf_rsp_valid  = 1'b0;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_bank;
    logic             bf_req_valid;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [LOG2N-2:0] bf_tw_addr;
    logic             err_unexp_rsp;
    logic [31:0]      cycle_count;
    logic [31:0]      stall_count;

    fft_stage_scheduler #(
        .N       (N),
        .LOG2N   (LOG2N),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .stage         (stage),
        .rd_bank       (rd_bank),
        .bf_req_valid  (bf_req_valid),
        .bf_req_ready  (bf_req_ready),
        .bf_addr_a     (bf_addr_a),
        .bf_addr_b     (bf_addr_b),
        .bf_tw_addr    (bf_tw_addr),
        .bf_rsp_valid  (bf_rsp_valid),
        .err_unexp_rsp (err_unexp_rsp),
        .cycle_count   (cycle_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stg;
        int a;
        int b;
        int tw;
        int bank;
    } req_t;

    req_t exp_q[$];
    int   n_chk      = 0;
    int   n_pass     = 0;
    int   acc_cnt    = 0;
    int   done_cnt   = 0;
    bit   mon_en     = 1'b0;
    bit   hs_pend    = 1'b0;
    // Responder/ready controls: mode values written by the main process only.
    int   ready_mode = 0;   // 0: always ready, 1: random
    int   rsp_mode   = 0;   // 0: one cycle after accept, 1: random, 2: withhold, 3: drain
    int   stall_req  = 0;
    int   kick_req   = 0;
    // Owned by the driver process.
    int   stall_seen = 0;
    int   stall_left = 0;
    int   kick_seen  = 0;
    int   inflight   = 0;
    int   max_inflight = 0;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    // Reference: every address with bit s clear pairs with its partner at +2^s,
    // in ascending order; twiddle index scales the in-span offset to N/2 steps.
    task automatic load_model();
        req_t r;
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            for (int a = 0; a < N; a++) begin
                if (((a >> s) & 1) == 0) begin
                    r.stg  = s;
                    r.a    = a;
                    r.b    = a + (1 << s);
                    r.tw   = (a % (1 << s)) * (N >> (s + 1));
                    r.bank = s % 2;
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic tick();
        req_t e;
        @(negedge clk);
        hs_pend = bf_req_valid && bf_req_ready;
        if (done) done_cnt++;
        if (mon_en && hs_pend) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("req_stage", int'(stage), e.stg);
                check("req_addr_a", int'(bf_addr_a), e.a);
                check("req_addr_b", int'(bf_addr_b), e.b);
                check("req_tw", int'(bf_tw_addr), e.tw);
                check("req_rd_bank", int'(rd_bank), e.bank);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            inflight = 0;
        end else begin
            if (hs_pend) inflight++;
            if (bf_rsp_valid && inflight > 0) inflight--;
        end
        if (inflight > max_inflight) max_inflight = inflight;
        case (rsp_mode)
            0:       bf_rsp_valid = hs_pend && reset;
            1:       bf_rsp_valid = (inflight > 0) && ($urandom_range(0, 2) == 0);
            2:       bf_rsp_valid = 1'b0;
            default: bf_rsp_valid = (inflight > 0);
        endcase
        if (kick_req != kick_seen) begin
            kick_seen    = kick_req;
            bf_rsp_valid = 1'b1;
        end
        if (stall_req != stall_seen) begin
            stall_seen = stall_req;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            bf_req_ready = 1'b0;
            stall_left--;
        end else begin
            bf_req_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic run_to_done(input bit poke);
        int  base;
        bit  seen;
        base = done_cnt;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            tick();
            if (done) seen = 1'b1;
            // Start while busy must be ignored.
            start = poke && busy && !done && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
        check("busy_at_done", int'(busy), 1);
        tick();
        check("busy_after_done", int'(busy), 0);
        check("done_pulse_count", done_cnt - base, 1);
        check("model_drained", exp_q.size(), 0);
    endtask

    task automatic begin_transform();
        load_model();
        mon_en = 1'b1;
        tick();
        check("busy_before_start", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_req_valid", int'(bf_req_valid), 1);
        check("first_req_addr_b", int'(bf_addr_b), 1);
    endtask

    initial begin
        int  base;
        int  a_cap, b_cap, tw_cap;
        bit  found;

        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(bf_req_valid), 0);
        check("rst_err", int'(err_unexp_rsp), 0);
        check("rst_stage", int'(stage), 0);
        check("rst_rd_bank", int'(rd_bank), 0);
        check("rst_addr_b", int'(bf_addr_b), 0);
        check("rst_stall_count", int'(stall_count), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Directed: ready=1, response one cycle after accept, one extra start mid-run.
        begin_transform();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(1'b0);

        // Responses withheld: only MAX_OUT accepts, then valid drops.
        rsp_mode = 2;
        base = acc_cnt;
        begin_transform();
        repeat (9) tick();
        check("maxout_accepts", acc_cnt - base, MAX_OUT);
        check("maxout_valid_low", int'(bf_req_valid), 0);
        check("maxout_busy", int'(busy), 1);
        rsp_mode = 3;
        run_to_done(1'b0);

        // Ready low for five cycles while pair 1 of stage 0 is pending.
        rsp_mode = 0;
        begin_transform();
        stall_req++;
        tick();
        a_cap  = int'(bf_addr_a);
        b_cap  = int'(bf_addr_b);
        tw_cap = int'(bf_tw_addr);
        check("stall_valid", int'(bf_req_valid), 1);
        repeat (4) tick();
        check("stall_addr_a", int'(bf_addr_a), 2);
        check("stall_addr_b", int'(bf_addr_b), 3);
        check("stall_hold_a", int'(bf_addr_a), a_cap);
        check("stall_hold_b", int'(bf_addr_b), b_cap);
        check("stall_hold_tw", int'(bf_tw_addr), tw_cap);
        run_to_done(1'b0);
`ifdef FFT_SCHED_STATS_EN
        check("stall_count", int'(stall_count), 5);
`else
        check("stall_count_tied", int'(stall_count), 0);
        check("cycle_count_tied", int'(cycle_count), 0);
`endif

        // Stray response while idle sets the sticky error.
        check("err_clean", int'(err_unexp_rsp), 0);
        kick_req++;
        repeat (3) tick();
        check("err_set", int'(err_unexp_rsp), 1);
        repeat (5) tick();
        check("err_sticky", int'(err_unexp_rsp), 1);

        // Randomized ready/response timing with stray start pulses.
        ready_mode = 1;
        rsp_mode   = 1;
        for (int i = 0; i < 4; i++) begin
            begin_transform();
            run_to_done(1'b1);
        end
        check("max_inflight_ok", int'(max_inflight <= MAX_OUT), 1);
        check("err_still_set", int'(err_unexp_rsp), 1);

        // Reset during stage 2: straight back to idle, no done pulse.
        ready_mode = 0;
        rsp_mode   = 0;
        begin_transform();
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            tick();
            if (stage == 3'd2 && bf_req_valid) found = 1'b1;
        end
        check("reached_stage2", int'(found), 1);
        mon_en   = 1'b0;
        rsp_mode = 2;
        reset    = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(bf_req_valid), 0);
        check("midrst_stage", int'(stage), 0);
        check("midrst_err", int'(err_unexp_rsp), 0);
        base = done_cnt;
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();
        check("midrst_no_done", done_cnt - base, 0);
        check("midrst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
